// File: rtl/segment_pattern_decoder_if.sv
// Seven-segment display bus as seen by the segment pattern decoder:
// the eight segment lines plus the decoded results reported back.
interface segment_pattern_decoder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   A, B, C, D, E, F, G, DP;
  logic [3:0]             binaryNumber;
  logic                   isError;
  logic                   isValid;
  logic                   isUnknown;
  logic                   updatePulse;
  logic [COUNT_WIDTH-1:0] updateCount;

  // Display driver / observer side
  modport master (
    output A, B, C, D, E, F, G, DP,
    input  binaryNumber, isError, isValid, isUnknown, updatePulse, updateCount
  );

  // Decoder side
  modport slave (
    input  A, B, C, D, E, F, G, DP,
    output binaryNumber, isError, isValid, isUnknown, updatePulse, updateCount
  );
endinterface

// File: rtl/segment_pattern_decoder.sv
// Segment pattern decoder: samples the seven-segment lines A..G and DP,
// filters out transient patterns, and recovers the hex digit / error code
// that the display driver encoded onto them.
// Optional macro SEG_SYNC_EN: inserts a two-flop synchronizer on all eight
// segment lines ahead of the sample register (adds 2 cycles of latency).
module segment_pattern_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                         clock,
  input  logic                         resetN,
  segment_pattern_decoder_if.slave     bus
);

  typedef enum logic [1:0] {EMPTY, SETTLING, LOCKED} state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  // ABCDEFG = 0000001 with DP = 1
  localparam logic [7:0] ERR_PAT    = 8'h03;

  // Returns {hit, value} for a 7-bit ABCDEFG code.
  function automatic logic [4:0] decode_digit(input logic [6:0] code);
    logic [4:0] res;
    case (code)
      7'h7E:   res = {1'b1, 4'h0};
      7'h30:   res = {1'b1, 4'h1};
      7'h6D:   res = {1'b1, 4'h2};
      7'h79:   res = {1'b1, 4'h3};
      7'h33:   res = {1'b1, 4'h4};
      7'h5B:   res = {1'b1, 4'h5};
      7'h5F:   res = {1'b1, 4'h6};
      7'h70:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h7B:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h1F:   res = {1'b1, 4'hB};
      7'h4E:   res = {1'b1, 4'hC};
      7'h3D:   res = {1'b1, 4'hD};
      7'h4F:   res = {1'b1, 4'hE};
      7'h47:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [7:0]             w_seg_in;
  logic [7:0]             w_seg;
  logic                   w_same;
  logic                   w_commit;
  logic                   w_load;
  logic [4:0]             w_dec;
  logic                   w_is_digit;
  logic                   w_is_err;
  state_t                 w_state_nxt;

  logic [7:0]             r_sample;
  logic [3:0]             r_cnt;
  logic [7:0]             r_committed;
  logic                   r_has_commit;
  state_t                 r_state;
  logic [3:0]             r_bin;
  logic                   r_err;
  logic                   r_valid;
  logic                   r_unk;
  logic                   r_pulse;
  logic [COUNT_WIDTH-1:0] r_count;

  assign w_seg_in = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G, bus.DP};

`ifdef SEG_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  // Two-flop synchronizer for segment lines driven from another clock domain
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_seg_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_seg = r_sync2;
`else
  assign w_seg = w_seg_in;
`endif

  // A candidate commits only once it has filled the stability counter and is
  // still present on the following edge; a change on that edge restarts it.
  // Re-committing the already committed pattern is suppressed.
  assign w_same     = (w_seg == r_sample);
  assign w_commit   = w_same && (r_cnt == STABLE_MAX) &&
                      (!r_has_commit || (r_sample != r_committed));
  assign w_dec      = decode_digit(r_sample[7:1]);
  assign w_is_digit = w_dec[4] && !r_sample[0];
  assign w_is_err   = (r_sample == ERR_PAT);

  // Sample register and saturating stability counter
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sample <= '0;
      r_cnt    <= '0;
    end else begin
      r_sample <= w_seg;
      if (!w_same)                 r_cnt <= 4'd1;
      else if (r_cnt < STABLE_MAX) r_cnt <= r_cnt + 4'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= EMPTY;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:    w_state_nxt = SETTLING;
      SETTLING: begin
        if (w_commit)
          w_state_nxt = LOCKED;
        else if (r_has_commit && (w_seg == r_committed))
          w_state_nxt = LOCKED;
      end
      LOCKED:   if (w_seg != r_committed) w_state_nxt = SETTLING;
      default:  w_state_nxt = EMPTY;
    endcase
  end

  // FSM output logic: a commit is only taken while settling on a candidate
  always_comb begin
    w_load = 1'b0;
    if (r_state == SETTLING) w_load = w_commit;
  end

  // Committed pattern, decoded results, update pulse and counter
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_committed  <= '0;
      r_has_commit <= 1'b0;
      r_bin        <= '0;
      r_err        <= 1'b0;
      r_valid      <= 1'b0;
      r_unk        <= 1'b0;
      r_pulse      <= 1'b0;
      r_count      <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_load) begin
        r_committed  <= r_sample;
        r_has_commit <= 1'b1;
        r_pulse      <= 1'b1;
        r_count      <= r_count + 1'b1;
        if (w_is_digit) begin
          r_bin   <= w_dec[3:0];
          r_err   <= 1'b0;
          r_unk   <= 1'b0;
          r_valid <= 1'b1;
        end else if (w_is_err) begin
          r_err   <= 1'b1;
          r_unk   <= 1'b0;
          r_valid <= 1'b1;
        end else begin
          r_err   <= 1'b0;
          r_unk   <= 1'b1;
        end
      end
    end
  end

  assign bus.binaryNumber = r_bin;
  assign bus.isError      = r_err;
  assign bus.isValid      = r_valid;
  assign bus.isUnknown    = r_unk;
  assign bus.updatePulse  = r_pulse;
  assign bus.updateCount  = r_count;

endmodule

// File: tb/tb_segment_pattern_decoder.sv
// Bench for segment_pattern_decoder: directed segment patterns with
// hand-computed results, a scoreboard queue filled by the stimulus and
// drained by a monitor on every updatePulse. A second instance with
// COUNT_WIDTH = 2 shares the segment lines to exercise counter wrap.
module tb_segment_pattern_decoder;

  typedef struct {
    logic [6:0] code;
    logic       dp;
    int         hold;
    bit         commit;
    logic [3:0] bin;
    bit         err;
    bit         unk;
  } vec_t;

  typedef struct {
    logic [3:0] bin;
    bit         err;
    bit         unk;
    bit         valid;
    int         cnt;
  } exp_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];
  vec_t vecs[$];

  logic [3:0] exp_bin   = 4'h0;
  bit         exp_err   = 1'b0;
  bit         exp_unk   = 1'b0;
  bit         exp_valid = 1'b0;
  int         exp_cnt   = 0;

  always #5 clock = ~clock;

  segment_pattern_decoder_if #(.COUNT_WIDTH(8)) bus0 ();
  segment_pattern_decoder_if #(.COUNT_WIDTH(2)) bus1 ();

  assign bus1.A  = bus0.A;
  assign bus1.B  = bus0.B;
  assign bus1.C  = bus0.C;
  assign bus1.D  = bus0.D;
  assign bus1.E  = bus0.E;
  assign bus1.F  = bus0.F;
  assign bus1.G  = bus0.G;
  assign bus1.DP = bus0.DP;

  segment_pattern_decoder #(.STABLE_CYCLES(3), .COUNT_WIDTH(8)) dut0 (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus0.slave)
  );

  segment_pattern_decoder #(.STABLE_CYCLES(3), .COUNT_WIDTH(2)) dut1 (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus1.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [6:0] code, input logic dp);
    {bus0.A, bus0.B, bus0.C, bus0.D, bus0.E, bus0.F, bus0.G} = code;
    bus0.DP = dp;
  endtask

  task automatic add(input logic [6:0] code, input logic dp, input int hold,
                     input bit commit, input logic [3:0] bin, input bit err, input bit unk);
    vec_t v;
    v.code = code; v.dp = dp; v.hold = hold; v.commit = commit;
    v.bin = bin; v.err = err; v.unk = unk;
    vecs.push_back(v);
  endtask

  task automatic check_steady(input string tag);
    chk({tag, "_bin"},   32'(bus0.binaryNumber), 32'(exp_bin));
    chk({tag, "_err"},   32'(bus0.isError),      32'(exp_err));
    chk({tag, "_unk"},   32'(bus0.isUnknown),    32'(exp_unk));
    chk({tag, "_valid"}, 32'(bus0.isValid),      32'(exp_valid));
    chk({tag, "_cnt"},   32'(bus0.updateCount),  32'(exp_cnt % 256));
    chk({tag, "_cnt2"},  32'(bus1.updateCount),  32'(exp_cnt % 4));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bin"},   32'(bus0.binaryNumber), 32'h0);
    chk({tag, "_err"},   32'(bus0.isError),      32'h0);
    chk({tag, "_unk"},   32'(bus0.isUnknown),    32'h0);
    chk({tag, "_valid"}, 32'(bus0.isValid),      32'h0);
    chk({tag, "_pulse"}, 32'(bus0.updatePulse),  32'h0);
    chk({tag, "_cnt"},   32'(bus0.updateCount),  32'h0);
    chk({tag, "_cnt2"},  32'(bus1.updateCount),  32'h0);
  endtask

  // Present one vector: queue the expected commit, hold it, then confirm
  // the outputs settled to the expected state.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    drive(v.code, v.dp);
    if (v.commit) begin
      exp_cnt++;
      exp_bin   = v.bin;
      exp_err   = v.err;
      exp_unk   = v.unk;
      exp_valid = 1'b1;
      e.bin = exp_bin; e.err = exp_err; e.unk = exp_unk;
      e.valid = exp_valid; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    repeat (v.hold) @(posedge clock);
    #1;
    check_steady($sformatf("vec%0d", idx));
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetN && bus0.updatePulse) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got pulse with bin %0h expected none at %0t",
                   bus0.binaryNumber, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_bin",    32'(bus0.binaryNumber), 32'(e.bin));
          chk("mon_err",    32'(bus0.isError),      32'(e.err));
          chk("mon_unk",    32'(bus0.isUnknown),    32'(e.unk));
          chk("mon_valid",  32'(bus0.isValid),      32'(e.valid));
          chk("mon_cnt",    32'(bus0.updateCount),  32'(e.cnt % 256));
          chk("mon_pulse2", 32'(bus1.updatePulse),  32'h1);
          chk("mon_cnt2",   32'(bus1.updateCount),  32'(e.cnt % 4));
        end
      end else if (resetN && bus1.updatePulse) begin
        chk("mon_pulse2_only", 32'(bus1.updatePulse), 32'h0);
      end
    end
  end

  initial begin
    // 0..F, each held 5 cycles
    add(7'h7E, 1'b0, 5, 1, 4'h0, 0, 0);
    add(7'h30, 1'b0, 5, 1, 4'h1, 0, 0);
    add(7'h6D, 1'b0, 5, 1, 4'h2, 0, 0);
    add(7'h79, 1'b0, 5, 1, 4'h3, 0, 0);
    add(7'h33, 1'b0, 5, 1, 4'h4, 0, 0);
    add(7'h5B, 1'b0, 5, 1, 4'h5, 0, 0);
    add(7'h5F, 1'b0, 5, 1, 4'h6, 0, 0);
    add(7'h70, 1'b0, 5, 1, 4'h7, 0, 0);
    add(7'h7F, 1'b0, 5, 1, 4'h8, 0, 0);
    add(7'h7B, 1'b0, 5, 1, 4'h9, 0, 0);
    add(7'h77, 1'b0, 5, 1, 4'hA, 0, 0);
    add(7'h1F, 1'b0, 5, 1, 4'hB, 0, 0);
    add(7'h4E, 1'b0, 5, 1, 4'hC, 0, 0);
    add(7'h3D, 1'b0, 5, 1, 4'hD, 0, 0);
    add(7'h4F, 1'b0, 5, 1, 4'hE, 0, 0);
    add(7'h47, 1'b0, 5, 1, 4'hF, 0, 0);
    // 9, then error pattern keeps 9, then 4 clears the error
    add(7'h7B, 1'b0, 5, 1, 4'h9, 0, 0);
    add(7'h01, 1'b1, 5, 1, 4'h9, 1, 0);
    add(7'h33, 1'b0, 5, 1, 4'h4, 0, 0);
    // Locked on 5; 2-cycle glitch to 8 and back: no commit
    add(7'h5B, 1'b0, 5, 1, 4'h5, 0, 0);
    add(7'h7F, 1'b0, 2, 0, 4'h5, 0, 0);
    add(7'h5B, 1'b0, 5, 0, 4'h5, 0, 0);
    // Exactly STABLE_CYCLES then change: change on the expiring edge, no commit
    add(7'h7F, 1'b0, 3, 0, 4'h5, 0, 0);
    add(7'h5B, 1'b0, 5, 0, 4'h5, 0, 0);
    // One more cycle is enough to commit
    add(7'h7F, 1'b0, 4, 1, 4'h8, 0, 0);
    add(7'h5B, 1'b0, 5, 1, 4'h5, 0, 0);
    // Digit with DP lit and a junk pattern: unknown, value held
    add(7'h7E, 1'b1, 5, 1, 4'h5, 0, 1);
    add(7'h55, 1'b0, 5, 1, 4'h5, 0, 1);

    // Reset state, with the first pattern already on the lines
    drive(vecs[0].code, vecs[0].dp);
    #1;
    check_zero("reset");
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset in the middle of settling on "1"
    drive(7'h30, 1'b0);
    repeat (2) @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    check_zero("midreset");
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    exp_bin = 4'h0; exp_err = 1'b0; exp_unk = 1'b0; exp_valid = 1'b0; exp_cnt = 0;

    // After release, "2" needs a full stable run and counts from 1 again
    drive(7'h6D, 1'b0);
    @(negedge clock);
    resetN = 1'b1;
    add(7'h6D, 1'b0, 5, 1, 4'h2, 0, 0);
    apply(vecs[vecs.size()-1], vecs.size()-1);

    repeat (3) @(posedge clock);
    #1;
    chk("final_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
